// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: plays short ROM note sequences (eat/level/hit) over the
// background track, with priority preemption and a registered note_gen interface.
module sfx_sequencer #(
  parameter int unsigned TICK_DIV = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sfx_eat,
  input  logic        sfx_hit,
  input  logic        sfx_level,
  input  logic [21:0] bgm_note_div,
  input  logic        bgm_enable,
  output logic [21:0] note_div,
  output logic        enable_sound,
  output logic        sfx_busy,
  output logic        sfx_done
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StNote, StGap} state_e;
  // Encoding doubles as priority rank: larger value wins.
  typedef enum logic [1:0] {SeqEat = 2'd0, SeqLevel = 2'd1, SeqHit = 2'd2} seq_e;

  state_e        state_q, state_d;
  seq_e          seq_q, seq_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    tcnt_q, tcnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [21:0]   note_div_q, note_div_d;
  logic          enable_q, enable_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          tick;
  logic          ev_valid;
  seq_e          ev_seq;

  function automatic logic [21:0] rom_div(input seq_e s, input logic [1:0] i);
    logic [21:0] d;
    d = 22'd0;
    case (s)
      SeqEat: begin
        case (i)
          2'd0:    d = 22'd127551;
          default: d = 22'd95511;
        endcase
      end
      SeqLevel: begin
        case (i)
          2'd0:    d = 22'd191204;
          2'd1:    d = 22'd151745;
          2'd2:    d = 22'd127551;
          default: d = 22'd95511;
        endcase
      end
      default: begin
        case (i)
          2'd0:    d = 22'd127551;
          2'd1:    d = 22'd151745;
          default: d = 22'd255102;
        endcase
      end
    endcase
    return d;
  endfunction

  function automatic logic [3:0] rom_ticks(input seq_e s, input logic [1:0] i);
    logic [3:0] t;
    t = 4'd0;
    case (s)
      SeqEat:   t = 4'd3;
      SeqLevel: t = (i == 2'd3) ? 4'd8 : 4'd4;
      default:  t = (i == 2'd2) ? 4'd12 : 4'd6;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] last_idx(input seq_e s);
    logic [1:0] l;
    case (s)
      SeqEat:   l = 2'd1;
      SeqLevel: l = 2'd3;
      default:  l = 2'd2;
    endcase
    return l;
  endfunction

  always_comb begin
    ev_valid = sfx_hit | sfx_level | sfx_eat;
    if (sfx_hit) begin
      ev_seq = SeqHit;
    end else if (sfx_level) begin
      ev_seq = SeqLevel;
    end else begin
      ev_seq = SeqEat;
    end
  end

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    idx_d      = idx_q;
    tcnt_d     = tcnt_q;
    done_d     = 1'b0;
    note_div_d = note_div_q;
    enable_d   = 1'b0;
    busy_d     = 1'b0;

    tick    = (state_q != StIdle) && (presc_q == PrescMax);
    presc_d = ((state_q == StIdle) || tick) ? '0 : presc_q + 1'b1;

    case (state_q)
      StNote: begin
        if (tick) begin
          if (tcnt_q == rom_ticks(seq_q, idx_q) - 4'd1) begin
            state_d = StGap;
            tcnt_d  = 4'd0;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      StGap: begin
        if (tick) begin
          tcnt_d = 4'd0;
          if (idx_q == last_idx(seq_q)) begin
            state_d = StIdle;
            idx_d   = 2'd0;
            done_d  = 1'b1;
          end else begin
            state_d = StNote;
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      default: begin
      end
    endcase

    // Completion edge counts as idle, so any event there starts a new sequence;
    // done_d is left set for the sequence that just finished.
    if (ev_valid && ((state_d == StIdle) || (ev_seq > seq_q))) begin
      state_d = StNote;
      seq_d   = ev_seq;
      idx_d   = 2'd0;
      tcnt_d  = 4'd0;
      presc_d = '0;
    end

    case (state_d)
      StNote: begin
        note_div_d = rom_div(seq_d, idx_d);
        enable_d   = 1'b1;
        busy_d     = 1'b1;
      end
      StGap: begin
        note_div_d = rom_div(seq_d, idx_d);
        busy_d     = 1'b1;
      end
      default: begin
        note_div_d = bgm_note_div;
        enable_d   = bgm_enable;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      seq_q      <= SeqEat;
      idx_q      <= 2'd0;
      tcnt_q     <= 4'd0;
      presc_q    <= '0;
      note_div_q <= 22'd0;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      idx_q      <= idx_d;
      tcnt_q     <= tcnt_d;
      presc_q    <= presc_d;
      note_div_q <= note_div_d;
      enable_q   <= enable_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign note_div     = note_div_q;
  assign enable_sound = enable_q;
  assign sfx_busy     = busy_q;
  assign sfx_done     = done_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Scoreboard bench for sfx_sequencer at TICK_DIV = 4: stimulus queues per-cycle
// expected outputs, a negedge monitor pops and compares them.
module tb_sfx_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sfx_eat, sfx_hit, sfx_level;
  logic [21:0] bgm_note_div;
  logic        bgm_enable;
  logic [21:0] note_div;
  logic        enable_sound, sfx_busy, sfx_done;

  sfx_sequencer #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sfx_eat     (sfx_eat),
    .sfx_hit     (sfx_hit),
    .sfx_level   (sfx_level),
    .bgm_note_div(bgm_note_div),
    .bgm_enable  (bgm_enable),
    .note_div    (note_div),
    .enable_sound(enable_sound),
    .sfx_busy    (sfx_busy),
    .sfx_done    (sfx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] div;
    logic        en;
    logic        busy;
    logic        done;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  logic [21:0] cur_div;
  logic        cur_en;

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      tests++;
      if (note_div !== mon_e.div || enable_sound !== mon_e.en ||
          sfx_busy !== mon_e.busy || sfx_done !== mon_e.done) begin
        fails++;
        $display("FAIL %s @cyc %0d: got div=%0d en=%0b busy=%0b done=%0b, want div=%0d en=%0b busy=%0b done=%0b",
                 mon_e.tag, cyc, note_div, enable_sound, sfx_busy, sfx_done,
                 mon_e.div, mon_e.en, mon_e.busy, mon_e.done);
      end
    end
  end

  task automatic push(input logic [21:0] div, input logic en, input logic busy,
                      input logic done, input int n, input string tag);
    exp_t e;
    e.div = div; e.en = en; e.busy = busy; e.done = done; e.tag = tag;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // One ROM entry at TICK_DIV=4: ticks*4 cycles sounding, then a 4-cycle gap.
  task automatic push_note(input logic [21:0] div, input int ticks, input string tag);
    push(div, 1'b1, 1'b1, 1'b0, ticks * 4, tag);
    push(div, 1'b0, 1'b1, 1'b0, 4, {tag, "_gap"});
  endtask

  task automatic push_end(input string tag);
    push(cur_div, cur_en, 1'b0, 1'b1, 1, {tag, "_done"});
    push(cur_div, cur_en, 1'b0, 1'b0, 2, {tag, "_idle"});
  endtask

  task automatic push_eat(input string tag);
    push_note(22'd127551, 3, {tag, "_eat0"});
    push_note(22'd95511, 3, {tag, "_eat1"});
  endtask

  task automatic push_level_tail(input string tag);
    push_note(22'd151745, 4, {tag, "_lvl1"});
    push_note(22'd127551, 4, {tag, "_lvl2"});
    push_note(22'd95511, 8, {tag, "_lvl3"});
  endtask

  task automatic push_hit(input string tag);
    push_note(22'd127551, 6, {tag, "_hit0"});
    push_note(22'd151745, 6, {tag, "_hit1"});
    push_note(22'd255102, 12, {tag, "_hit2"});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: %0d entries left, want 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; sfx_eat = 1'b0; sfx_hit = 1'b0; sfx_level = 1'b0;
    bgm_note_div = 22'd1000; bgm_enable = 1'b1;
    cur_div = 22'd1000; cur_en = 1'b1;

    // Reset state, then first edge after release loads bgm.
    repeat (3) @(posedge clk);
    push(22'd0, 1'b0, 1'b0, 1'b0, 1, "reset");
    #1 rst = 1'b0;
    @(posedge clk);
    push(22'd1000, 1'b1, 1'b0, 1'b0, 2, "bgm_after_rst");
    drain("rst");

    // Idle passthrough of new bgm values.
    #1 bgm_note_div = 22'd151745; bgm_enable = 1'b1;
    cur_div = 22'd151745; cur_en = 1'b1;
    @(posedge clk);
    push(22'd151745, 1'b1, 1'b0, 1'b0, 2, "bgm_pass");
    drain("bgm");

    // Eat, with a same-effect retrigger and a bgm change while busy.
    #1 sfx_eat = 1'b1;
    @(posedge clk);
    cur_div = 22'd2222; cur_en = 1'b0;
    push_eat("s1");
    push_end("s1");
    #1 sfx_eat = 1'b0;
    repeat (2) @(posedge clk);
    #1 sfx_eat = 1'b1;
    @(posedge clk);
    #1 sfx_eat = 1'b0;
    repeat (6) @(posedge clk);
    #1 bgm_note_div = 22'd2222; bgm_enable = 1'b0;
    drain("s1");

    // Eat, then level landing on the GAP->IDLE edge: done pulses and level starts.
    #1 sfx_eat = 1'b1;
    @(posedge clk);
    push_eat("s7");
    push(22'd191204, 1'b1, 1'b1, 1'b1, 1, "s7_boundary");
    push(22'd191204, 1'b1, 1'b1, 1'b0, 15, "s7_lvl0");
    push(22'd191204, 1'b0, 1'b1, 1'b0, 4, "s7_lvl0_gap");
    push_level_tail("s7");
    push_end("s7");
    #1 sfx_eat = 1'b0;
    repeat (31) @(posedge clk);
    #1 sfx_level = 1'b1;
    @(posedge clk);
    #1 sfx_level = 1'b0;
    drain("s7");

    // All three pulses together: hit wins.
    #1 sfx_eat = 1'b1; sfx_level = 1'b1; sfx_hit = 1'b1;
    @(posedge clk);
    push_hit("s2");
    push_end("s2");
    #1 sfx_eat = 1'b0; sfx_level = 1'b0; sfx_hit = 1'b0;
    drain("s2");

    // Eat preempted by hit five cycles later; no done for the eat.
    #1 sfx_eat = 1'b1;
    @(posedge clk);
    push(22'd127551, 1'b1, 1'b1, 1'b0, 5, "s3_eat0");
    push_hit("s3");
    push_end("s3");
    #1 sfx_eat = 1'b0;
    repeat (4) @(posedge clk);
    #1 sfx_hit = 1'b1;
    @(posedge clk);
    #1 sfx_hit = 1'b0;
    drain("s3");

    // Level with a lower-priority eat during note 2: ignored.
    #1 sfx_level = 1'b1;
    @(posedge clk);
    push_note(22'd191204, 4, "s4_lvl0");
    push_level_tail("s4");
    push_end("s4");
    #1 sfx_level = 1'b0;
    repeat (24) @(posedge clk);
    #1 sfx_eat = 1'b1;
    @(posedge clk);
    #1 sfx_eat = 1'b0;
    drain("s4");

    // Reset mid-hit with a coincident eat: abort, no done, then bgm passthrough.
    #1 sfx_hit = 1'b1;
    @(posedge clk);
    push(22'd127551, 1'b1, 1'b1, 1'b0, 10, "s6_hit0");
    #1 sfx_hit = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1; sfx_eat = 1'b1;
    @(posedge clk);
    push(22'd0, 1'b0, 1'b0, 1'b0, 1, "s6_reset");
    #1 rst = 1'b0; sfx_eat = 1'b0;
    @(posedge clk);
    push(22'd2222, 1'b0, 1'b0, 1'b0, 3, "s6_bgm");
    drain("s6");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
